button_press_encoder: RTL and testbench
=======================================

// Module: button_press_encoder
// PURPOSE
//  Input stage of the Simon game, upstream of the DFlip register and game FSM.
//  - Takes the four raw player push-buttons and synchronises and debounces each one.
//  - Turns each clean press into one 2-bit colour code.
//  - Holds that code under a valid/ready handshake until the consumer takes it.
//  - Flags rejected (multi-button) and dropped (overrun) presses.
// PARAMETERS
//  NUM_BTN          4   number of buttons; fixed to 4 for the colour encoding
//  DEBOUNCE_CYCLES  16  consecutive stable cycles needed to accept a level change (board build: 500000)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//  clock      in   1  single system clock; all logic on rising edge
//  reset      in   1  synchronous, active-high; sampled on rising edge of clock
//  buttons    in   4  raw asynchronous pad inputs, active-high; bit0=GREEN 1=RED 2=YELLOW 3=BLUE
//  ready      in   1  consumer accepts color this cycle when valid&&ready
//  valid      out  1  color holds an unconsumed press
//  color      out  2  encoded button of the held press
//  multi_err  out  1  one-cycle pulse: >1 debounced rising edge in the same cycle, press discarded
//  overrun    out  1  one-cycle pulse: new press arrived while valid&&!ready, new press dropped
// BEHAVIOUR
//  Reset (synchronous): clears every flop.
//  - Sync flops, stable levels, counters, valid, color, multi_err and overrun all go to 0.
//  - Reset mid-debounce discards the partial count.
//  - Reset while valid drops the held press.
//  Per button, three stages:
//  - 2-flop synchroniser produces sync.
//  - Debounce:
//    - If sync==stable, the counter clears to 0.
//    - Else the counter increments.
//    - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, stable<=sync and the counter clears.
//    - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//  - Edge detect: rise = stable flips 0->1 this cycle.
//  - Release (1->0) produces no event.
//  - A held button produces exactly one event.
//  Encode (combinational on rise[3:0]):
//  - Exactly one bit set: press event, code = index of that bit.
//  - Two or more bits set: no press event; multi_err=1 for the next cycle only.
//  Output register, two states:
//  - EMPTY (valid=0):
//    - On a press event: color<=code, valid<=1, go to FULL.
//  - FULL (valid=1):
//    - color is held constant.
//    - ready=1 with no press event: valid<=0, go to EMPTY.
//    - ready=1 with a press event in the same cycle: color<=new code, valid stays 1.
//    - ready=0 with a press event: keep the old code; overrun=1 for the next cycle.
//  - ready is ignored while valid=0.
//  Latency: a raw input held clean from before rising edge k gives valid=1 after edge k+DEBOUNCE_CYCLES+2.
//  - Total is DEBOUNCE_CYCLES+3 edges: 2 sync + DEBOUNCE_CYCLES debounce + 1 output.
//  - No combinational path from buttons or ready to any output.
//  Simultaneous events:
//  - multi_err and overrun can both be 1 in the same cycle.
//  - A multi-press while FULL sets only multi_err.
// STRUCTURE
//  simon_pkg (shared): localparams COLOR_GREEN=2'd0, COLOR_RED=2'd1, COLOR_YELLOW=2'd2, COLOR_BLUE=2'd3, NUM_BTN=4.
//  - The game FSM and LED driver reuse these constants.
//  Sub-module debounce_bit (clock, reset, raw -> stable, rise):
//  - Contains the synchroniser, counter and edge detect.
//  - Instantiated NUM_BTN times in a generate loop.
//  - Encoder and output register are inline in button_press_encoder.
// TESTING  (bench runs DEBOUNCE_CYCLES=4, clock period 2)
//  1 Reset:
//    - Stimulus: reset=1 for 2 edges with buttons=4'b1111, then release reset.
//    - Required: valid=0, multi_err=0, overrun=0 during reset.
//    - Required: valid=0 until 7 edges after release, then a single multi_err pulse, and valid stays 0.
//  2 Clean press:
//    - Stimulus: buttons=4'b0100 from edge 10, ready=0.
//    - Required: valid=1 with color=2'd2 after edge 16; held while ready=0.
//    - Required: with ready=1 at edge 20, valid=0 after edge 20.
//  3 Glitch rejection:
//    - Stimulus: buttons[1] high for 3 cycles, then low.
//    - Required: valid never asserts.
//    - Stimulus: then held high for 4+ cycles.
//    - Required: valid=1, color=2'd1.
//  4 Hold and release:
//    - Stimulus: buttons[3] held 40 cycles, ready=1 throughout.
//    - Required: exactly one valid cycle with color=2'd3; release gives no event.
//  5 Overrun and back-to-back:
//    - Stimulus: BLUE press with ready=0, then a GREEN press completes debounce.
//    - Required: overrun pulses 1 cycle; color stays 2'd3.
//    - Stimulus: repeat with ready=1 on GREEN's event cycle.
//    - Required: color=2'd0, valid stays 1.
//  6 Reset mid-operation:
//    - Stimulus: assert reset when a debounce counter is at 2, and separately when valid=1.
//    - Required: all outputs 0 next edge.
//    - Required: a still-held button needs a full 7-edge latency again.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared constants and types for the Simon game datapath.
//                The colour codes are reused by the game FSM and the LED
//                driver, so they are the single source of truth for the
//                button-to-colour mapping.
//  Contents    : COLOR_* codes, NUM_BTN, output-register state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam logic [1:0] COLOR_GREEN  = 2'd0;
    localparam logic [1:0] COLOR_RED    = 2'd1;
    localparam logic [1:0] COLOR_YELLOW = 2'd2;
    localparam logic [1:0] COLOR_BLUE   = 2'd3;

    localparam int NUM_BTN = 4;

    // Output register: EMPTY means no press is waiting for the consumer.
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage : simon_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One button lane: 2-flop synchroniser, stable-level debounce
//                counter and rising-edge detector on the debounced level.
//  Ports       : clock  - system clock, rising edge
//                reset  - synchronous, active-high
//                raw    - asynchronous pad input, active-high
//                rise   - one-cycle pulse when the debounced level goes 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_stable_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_meta     <= raw;
            r_sync     <= r_meta;
            r_stable_q <= r_stable;
            // The counter measures how long the synchronised level has
            // disagreed with the accepted level; any agreement restarts it,
            // so only an uninterrupted run of DEBOUNCE_CYCLES mismatches
            // moves the accepted level.
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Driven only by flops, so no combinational path from the pad.
    assign rise = r_stable & ~r_stable_q;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/button_press_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : button_press_encoder
//  Description : Simon game input stage. Debounces four player buttons,
//                encodes a single clean press into a 2-bit colour code and
//                holds it under a valid/ready handshake.
//  Ports       : clock     - system clock, rising edge
//                reset     - synchronous, active-high
//                buttons   - raw pads, bit0=GREEN 1=RED 2=YELLOW 3=BLUE
//                ready     - consumer takes color when valid && ready
//                valid     - color holds an unconsumed press
//                color     - colour code of the held press
//                multi_err - pulse: several buttons rose together, discarded
//                overrun   - pulse: press arrived while valid && !ready, dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module button_press_encoder #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic               ready,
    output logic               valid,
    output logic [1:0]         color,
    output logic               multi_err,
    output logic               overrun
);

    import simon_pkg::*;

    logic [NUM_BTN-1:0] w_rise;

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock (clock),
                .reset (reset),
                .raw   (buttons[g]),
                .rise  (w_rise[g])
            );
        end
    endgenerate

    // ---------------------------------------------------------------- encoder
    logic [2:0] w_rise_cnt;
    logic [1:0] w_code;
    logic       w_press;
    logic       w_multi;

    always_comb begin
        w_rise_cnt = '0;
        w_code     = COLOR_GREEN;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_rise[i]) begin
                w_rise_cnt = w_rise_cnt + 3'd1;
                w_code     = 2'(i);
            end
        end
        // w_code is only meaningful when exactly one lane rose.
        w_press = (w_rise_cnt == 3'd1);
        w_multi = (w_rise_cnt > 3'd1);
    end

    // -------------------------------------------------------- output register
    out_state_e r_state;
    out_state_e w_state_n;
    logic [1:0] r_color;
    logic [1:0] w_color_n;
    logic       r_multi_err;
    logic       r_overrun;
    logic       w_overrun_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= OUT_EMPTY;
            r_color     <= 2'd0;
            r_multi_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_color     <= w_color_n;
            r_multi_err <= w_multi;
            r_overrun   <= w_overrun_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_color_n   = r_color;
        w_overrun_n = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (w_press) begin
                    w_state_n = OUT_FULL;
                    w_color_n = w_code;
                end
            end
            OUT_FULL: begin
                if (ready) begin
                    // A press landing on the hand-off cycle replaces the
                    // consumed code without a bubble.
                    if (w_press) begin
                        w_color_n = w_code;
                    end else begin
                        w_state_n = OUT_EMPTY;
                    end
                end else if (w_press) begin
                    w_overrun_n = 1'b1;
                end
            end
            default: begin
                w_state_n = OUT_EMPTY;
            end
        endcase
    end

    assign valid     = (r_state == OUT_FULL);
    assign color     = r_color;
    assign multi_err = r_multi_err;
    assign overrun   = r_overrun;

endmodule : button_press_encoder
`default_nettype wire

// File: tb/tb_button_press_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_press_encoder
//  Description : Self-checking bench for button_press_encoder with
//                DEBOUNCE_CYCLES=4 and a 2-unit clock. Expected colour codes
//                are queued when a press is driven and popped when valid
//                appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_press_encoder;

    import simon_pkg::*;

    localparam int DEB     = 4;
    localparam int LATENCY = DEB + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic       ready;
    logic       valid;
    logic [1:0] color;
    logic       multi_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    button_press_encoder #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .buttons   (buttons),
        .ready     (ready),
        .valid     (valid),
        .color     (color),
        .multi_err (multi_err),
        .overrun   (overrun)
    );

    always #1 clock = ~clock;

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        int seen;
        reset   = 1'b1;
        buttons = 4'b1111;
        ready   = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clock);
            checks++;
            if (valid !== 1'b0 || multi_err !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got v=%b m=%b o=%b exp 0 0 0", valid, multi_err, overrun);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= LATENCY + 1; n++) begin
            @(negedge clock);
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_multi_valid edge %0d got %b exp 0", n, valid);
            end
            checks++;
            if (multi_err !== (n == LATENCY)) begin
                errors++;
                $display("FAIL reset_multi_pulse edge %0d got %b exp %b", n, multi_err, (n == LATENCY));
            end
        end
        buttons = 4'b0000;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (valid === 1'b1 || multi_err === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_release_quiet got %0d event cycles exp 0", seen);
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] e;
        buttons = 4'b0100;
        exp_q.push_back(COLOR_YELLOW);
        for (int n = 1; n <= LATENCY; n++) begin
            @(negedge clock);
            checks++;
            if (valid !== (n == LATENCY)) begin
                errors++;
                $display("FAIL press_latency edge %0d got %b exp %b", n, valid, (n == LATENCY));
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL press_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL press_color got %0d exp %0d", color, e);
            end
        end
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (valid !== 1'b1 || color !== COLOR_YELLOW) begin
                errors++;
                $display("FAIL press_hold got v=%b c=%0d exp v=1 c=2", valid, color);
            end
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL press_consume got %b exp 0", valid);
        end
        buttons = 4'b0000;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_glitch();
        int seen;
        int lat;
        logic [1:0] e;
        buttons = 4'b0010;
        repeat (DEB - 1) @(negedge clock);
        buttons = 4'b0000;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL glitch_reject got %0d valid cycles exp 0", seen);
        end
        buttons = 4'b0010;
        exp_q.push_back(COLOR_RED);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (valid === 1'b1 && lat < 0) lat = n;
            if (lat >= 0) break;
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL glitch_accept_latency got %0d exp %0d", lat, LATENCY);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL glitch_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL glitch_color got %0d exp %0d", color, e);
            end
        end
        ready = 1'b1;
        @(negedge clock);
        ready   = 1'b0;
        buttons = 4'b0000;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_hold_release();
        int cnt;
        int seen;
        logic [1:0] e;
        ready   = 1'b1;
        buttons = 4'b1000;
        exp_q.push_back(COLOR_BLUE);
        cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL hold_color got %0d exp no event", color);
                end else begin
                    e = exp_q.pop_front();
                    if (color !== e) begin
                        errors++;
                        $display("FAIL hold_color got %0d exp %0d", color, e);
                    end
                end
            end
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL hold_single_event got %0d valid cycles exp 1", cnt);
        end
        buttons = 4'b0000;
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL release_no_event got %0d valid cycles exp 0", seen);
        end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [1:0] e;
        ready   = 1'b0;
        buttons = 4'b1000;
        exp_q.push_back(COLOR_BLUE);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (valid === 1'b1 && lat < 0) lat = n;
            if (lat >= 0) break;
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d exp %0d", lat, LATENCY);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_first_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL b2b_first_color got %0d exp %0d", color, e);
            end
        end
        // GREEN arrives while BLUE is still unconsumed: must be dropped.
        buttons = 4'b1001;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (overrun === 1'b1 && lat < 0) lat = n;
            if (lat >= 0) break;
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL overrun_latency got %0d exp %0d", lat, LATENCY);
        end
        checks++;
        if (valid !== 1'b1 || color !== COLOR_BLUE) begin
            errors++;
            $display("FAIL overrun_keep got v=%b c=%0d exp v=1 c=3", valid, color);
        end
        @(negedge clock);
        checks++;
        if (overrun !== 1'b0 || color !== COLOR_BLUE) begin
            errors++;
            $display("FAIL overrun_pulse got o=%b c=%0d exp o=0 c=3", overrun, color);
        end
        buttons = 4'b1000;
        repeat (10) @(negedge clock);
        // Second GREEN press, consumer ready exactly on its event cycle.
        buttons = 4'b1001;
        repeat (LATENCY - 1) @(negedge clock);
        checks++;
        if (valid !== 1'b1 || color !== COLOR_BLUE) begin
            errors++;
            $display("FAIL b2b_pre got v=%b c=%0d exp v=1 c=3", valid, color);
        end
        ready = 1'b1;
        exp_q.push_back(COLOR_GREEN);
        @(negedge clock);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_handoff got v=%b o=%b exp v=1 o=0", valid, overrun);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL b2b_color got %0d exp %0d", color, e);
            end
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b exp 0", valid);
        end
        buttons = 4'b0000;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        buttons = 4'b1000;
        repeat (4) @(negedge clock);   // debounce counter now at 2
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (valid !== 1'b0 || multi_err !== 1'b0 || overrun !== 1'b0 || color !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_deb got v=%b m=%b o=%b c=%0d exp all 0", valid, multi_err, overrun, color);
        end
        exp_q.push_back(COLOR_BLUE);
        for (int n = 1; n <= LATENCY; n++) begin
            @(negedge clock);
            checks++;
            if (valid !== (n == LATENCY)) begin
                errors++;
                $display("FAIL rst_mid_deb_latency edge %0d got %b exp %b", n, valid, (n == LATENCY));
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rst_mid_deb_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL rst_mid_deb_color got %0d exp %0d", color, e);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (valid !== 1'b0 || multi_err !== 1'b0 || overrun !== 1'b0 || color !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_valid got v=%b m=%b o=%b c=%0d exp all 0", valid, multi_err, overrun, color);
        end
        exp_q.push_back(COLOR_BLUE);
        for (int n = 1; n <= LATENCY; n++) begin
            @(negedge clock);
            checks++;
            if (valid !== (n == LATENCY)) begin
                errors++;
                $display("FAIL rst_mid_valid_latency edge %0d got %b exp %b", n, valid, (n == LATENCY));
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rst_mid_valid_color got %0d exp queue entry", color);
        end else begin
            e = exp_q.pop_front();
            if (color !== e) begin
                errors++;
                $display("FAIL rst_mid_valid_color got %0d exp %0d", color, e);
            end
        end
        ready = 1'b1;
        @(negedge clock);
        ready   = 1'b0;
        buttons = 4'b0000;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_hold_release();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_press_encoder
`default_nettype wire
